// File: rtl/switch_debounce.sv
// Slide-switch conditioner: 2-flop synchroniser, per-bit stability filter and
// one-cycle rise/fall event pulses on the debounced level.
module switch_debounce #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned STABLE_CYCLES = 50000,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] swt_raw,
   output logic [WIDTH-1:0] swt_db,
   output logic [WIDTH-1:0] swt_rise,
   output logic [WIDTH-1:0] swt_fall
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_db;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic [CNT_W-1:0] r_cnt [WIDTH];

   // Plain flop-to-flop chain; nothing may sit between the two stages.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= swt_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Output follows the synchronised level only after CNT_MAX+1 consecutive
   // cycles of disagreement; any single cycle of agreement restarts the count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_db   <= '0;
         r_rise <= '0;
         r_fall <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            r_rise[i] <= 1'b0;
            r_fall[i] <= 1'b0;
            if (r_sync2[i] == r_db[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               r_cnt[i]  <= '0;
               r_db[i]   <= r_sync2[i];
               r_rise[i] <= r_sync2[i];
               r_fall[i] <= ~r_sync2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign swt_db   = r_db;
   assign swt_rise = r_rise;
   assign swt_fall = r_fall;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with STABLE_CYCLES=4: reset, clean steps,
// bounce rejection, pulse-width boundaries, reset mid-count, simultaneous bits.
module tb_switch_debounce;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned SC    = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] swt_raw;
   logic [WIDTH-1:0] swt_db;
   logic [WIDTH-1:0] swt_rise;
   logic [WIDTH-1:0] swt_fall;

   int n_vec;
   int n_err;

   switch_debounce #(
      .WIDTH        (WIDTH),
      .STABLE_CYCLES(SC),
      .CNT_W        ($clog2(SC))
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .swt_raw (swt_raw),
      .swt_db  (swt_db),
      .swt_rise(swt_rise),
      .swt_fall(swt_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] db,
                      input logic [3:0] rise, input logic [3:0] fall);
      n_vec++;
      assert ({swt_db, swt_rise, swt_fall} === {db, rise, fall})
      else begin
         n_err++;
         $error("FAIL %s: db/rise/fall got %b/%b/%b want %b/%b/%b",
                tag, swt_db, swt_rise, swt_fall, db, rise, fall);
      end
   endtask

   // Inputs were just driven; the output changes on the 6th edge (E1+5).
   task automatic expect_change(input string tag, input logic [3:0] old_db,
                                input logic [3:0] new_db, input logic [3:0] rise,
                                input logic [3:0] fall);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk({tag, "_hold"}, old_db, 4'b0000, 4'b0000);
      end
      step();
      chk({tag, "_edge"}, new_db, rise, fall);
      step();
      chk({tag, "_after"}, new_db, 4'b0000, 4'b0000);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      swt_raw = 4'b1111;

      // 1: reset values, then rise of all bits after release
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_hold", 4'b0000, 4'b0000, 4'b0000);
      end
      rst_n = 1'b1;
      expect_change("rst_release", 4'b0000, 4'b1111, 4'b1111, 4'b0000);

      // 2: clean steps
      swt_raw = 4'b0000;
      expect_change("all_fall", 4'b1111, 4'b0000, 4'b0000, 4'b1111);
      swt_raw = 4'b1010;
      expect_change("step_up", 4'b0000, 4'b1010, 4'b1010, 4'b0000);
      swt_raw = 4'b0000;
      expect_change("step_down", 4'b1010, 4'b0000, 4'b0000, 4'b1010);

      // 3: bit 0 toggling every 2 cycles never passes
      for (int t = 0; t < 20; t++) begin
         swt_raw[0] = ~swt_raw[0];
         for (int k = 0; k < 2; k++) begin
            step();
            chk("bounce", 4'b0000, 4'b0000, 4'b0000);
         end
      end
      for (int k = 0; k < 6; k++) begin
         step();
         chk("bounce_tail", 4'b0000, 4'b0000, 4'b0000);
      end

      // 4a: 3-cycle pulse on bit 1 rejected
      swt_raw[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("pulse3_hi", 4'b0000, 4'b0000, 4'b0000);
      end
      swt_raw[1] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("pulse3_lo", 4'b0000, 4'b0000, 4'b0000);
      end

      // 4b: 4-cycle pulse accepted; rise at E1+5, fall 4 edges later
      swt_raw[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("pulse4_hi", 4'b0000, 4'b0000, 4'b0000);
      end
      swt_raw[1] = 1'b0;
      step();
      chk("pulse4_pre", 4'b0000, 4'b0000, 4'b0000);
      step();
      chk("pulse4_rise", 4'b0010, 4'b0010, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("pulse4_held", 4'b0010, 4'b0000, 4'b0000);
      end
      step();
      chk("pulse4_fall", 4'b0000, 4'b0000, 4'b0010);
      step();
      chk("pulse4_after", 4'b0000, 4'b0000, 4'b0000);

      // 5: reset mid-count discards the partial count
      swt_raw[2] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("midrst_pre", 4'b0000, 4'b0000, 4'b0000);
      end
      rst_n = 1'b0;
      step();
      chk("midrst_in", 4'b0000, 4'b0000, 4'b0000);
      rst_n = 1'b1;
      expect_change("midrst_rel", 4'b0000, 4'b0100, 4'b0100, 4'b0000);

      // 6: simultaneous independent rise and fall
      swt_raw = 4'b0101;
      expect_change("sim_setup", 4'b0100, 4'b0101, 4'b0001, 4'b0000);
      swt_raw = 4'b1010;
      expect_change("sim_swap", 4'b0101, 4'b1010, 4'b1010, 4'b0101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Conditions raw slide-switch inputs before they reach the LED light stage. Each bit is synchronised into the clock domain, filtered so that only levels held stable for a programmable number of cycles pass through, and presented as a clean bus with one-cycle rise/fall event pulses. `swt_db` drives the light stage's `swt` input directly.

## Interface
- `WIDTH`, 4: number of switch bits.
- `STABLE_CYCLES`, 50000: consecutive cycles a synchronised level must differ from the current output before the output follows it (1 ms at 50 MHz). Legal range 2 to 2^20.
- `CNT_W`, $clog2(STABLE_CYCLES): width of the per-bit counter.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `swt_raw` input WIDTH: asynchronous, bouncing switch levels.
- `swt_db` output WIDTH: debounced level. Feeds the light stage.
- `swt_rise` output WIDTH: one-cycle pulse when a `swt_db` bit goes 0→1.
- `swt_fall` output WIDTH: one-cycle pulse when a `swt_db` bit goes 1→0.

## Operation
- **Synchroniser.** Per bit, a 2-flop chain `sync1` → `sync2`. No logic sits between the flops.
- **Filter.** Each bit has an independent counter `cnt[i]` (CNT_W bits) and an output register `db[i]`.
  - If `sync2[i] == db[i]`: `cnt[i]` ← 0.
  - If they differ and `cnt[i] < STABLE_CYCLES-1`: `cnt[i]` ← `cnt[i]+1`.
  - If they differ and `cnt[i] == STABLE_CYCLES-1`: `db[i]` ← `sync2[i]`, `cnt[i]` ← 0, and the matching event register is set for exactly one cycle.
- **Glitch rejection.** A single cycle of agreement clears the counter, so the full interval restarts. A bounce shorter than STABLE_CYCLES never reaches `swt_db`.
- **Counter bounds.** The counter never exceeds STABLE_CYCLES-1 and never wraps.
- **Events.** `swt_rise[i]` is set when `db[i]` goes 0→1. `swt_fall[i]` is set when `db[i]` goes 1→0. A bit never has both set in the same cycle, and each pulse is registered for exactly one cycle.
- **Bit independence.** Bits are fully independent. Several bits may change and pulse in the same cycle.
- **Reset.** While `rst_n` is low at a rising edge, `sync1`, `sync2`, `cnt`, `swt_db`, `swt_rise` and `swt_fall` all become 0.
  - Asserting reset mid-count discards the partial count.
  - After release, a switch that is high counts from zero, and `swt_db` rises only after the full latency below.
  - Reset produces no event pulses.

## Timing
- **Latency.** `swt_raw[i]` changes and is then held steady before edge E1. `swt_db[i]` changes immediately after edge E1+STABLE_CYCLES+1:
  - 2 edges of synchroniser.
  - STABLE_CYCLES edges of filter; the last filter edge is the one that updates `db[i]`, which is why the total is STABLE_CYCLES+1 edges after E1.
- **Event timing.** The event pulse is high in the same cycle that `swt_db` first shows the new value.
- **Minimum spacing.** Two accepted transitions on one bit are at least STABLE_CYCLES cycles apart.
- **Reset outputs.** During reset and for the first cycle after release, all outputs are 0.
- **No handshake.** Consumers sample `swt_db` every cycle.

## Test plan
All scenarios use STABLE_CYCLES=4 unless stated.
1. **Reset values.** Hold `rst_n`=0 for 3 cycles with `swt_raw`=4'b1111 → `swt_db`=0 and `swt_rise`=`swt_fall`=0 throughout. After release, `swt_db`=4'b1111 appears after E1+5 (E1 = first edge after release), with `swt_rise`=4'b1111 for exactly one cycle.
2. **Clean step.** From `swt_db`=0, set `swt_raw`=4'b1010 and hold → `swt_db`=4'b1010 at E1+5 and `swt_rise`=4'b1010 for one cycle. Then set `swt_raw`=4'b0000 → `swt_fall`=4'b1010 for one cycle and `swt_db`=0 five edges later.
3. **Bounce rejection.** Toggle `swt_raw[0]` every 2 cycles for 40 cycles, then leave it at 0 → `swt_db[0]` stays 0 and `swt_rise[0]`/`swt_fall[0]` never assert.
4. **Boundary pulse widths.**
   - A high pulse of 3 cycles on `swt_raw[1]` is rejected.
   - A pulse of exactly 4 cycles is accepted, followed by a fall 4 cycles after the raw level drops.
   - Check both `swt_db[1]` transitions.
5. **Reset mid-count.** Raise `swt_raw[2]`, assert `rst_n`=0 two edges later for one cycle, and keep `swt_raw[2]`=1 → `swt_db[2]` rises only at release+5 edges, not earlier.
6. **Simultaneous independent bits.** Drive `swt_raw` from 4'b0101 (settled) to 4'b1010 in one cycle → in the same single cycle, `swt_rise`=4'b1010 and `swt_fall`=4'b0101, and `swt_db`=4'b1010.
